// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes and frame width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

  localparam int DATA_BITS   = 8;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

endpackage

// File: rtl/baud_tick_gen.sv
// Baud tick generator: one-cycle tick every DIV clocks while enabled.
// Latency: first tick DIV clocks after en rises; counter clears whenever en is low.
// Backpressure: none; free-running while enabled.
module baud_tick_gen #(
  parameter int DIV = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Count 0..DIV-1 while enabled, wrap at terminal count, hold at zero when disabled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 8N/E/O with 1 or 2 stop bits, LSB first, registered tx line.
// Latency: start bit on tx the edge after accept; frame is (1+8+P+S)*DIV clocks to tx_done.
// Backpressure: tx_ready low for the whole frame; tx_valid while busy is dropped, not queued.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int BAUD      = 9600,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] shift;
  logic [7:0] shift_nxt;
  logic [2:0] bit_idx;
  logic       stop_idx;
  logic       stop_last;
  logic       par_bit;
  logic       tick;
  logic       baud_en;
  logic       accept;
  logic       tx_nxt;
  logic       done_nxt;

  assign tx_ready  = (state == ST_IDLE);
  assign busy      = !tx_ready;
  assign accept    = tx_valid && tx_ready;
  assign baud_en   = (state != ST_IDLE);
  assign stop_last = (STOP_BITS == 1) || stop_idx;

  baud_tick_gen #(
    .DIV (DIV)
  ) u_baud (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (baud_en),
    .tick  (tick)
  );

  // State register; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: every non-idle state advances only on a baud terminal count.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (tx_valid) state_nxt = ST_START;
      ST_START:  if (tick) state_nxt = ST_DATA;
      ST_DATA:   if (tick && bit_idx == LAST_BIT)
                   state_nxt = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (tick) state_nxt = ST_STOP;
      ST_STOP:   if (tick && stop_last) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Output decode: next line level and done pulse, computed from the upcoming state.
  always_comb begin
    shift_nxt = shift;
    if (accept) begin
      shift_nxt = tx_data;
    end else if (state == ST_DATA && tick) begin
      shift_nxt = shift >> 1;
    end

    tx_nxt = 1'b1;
    case (state_nxt)
      ST_IDLE:   tx_nxt = 1'b1;
      ST_START:  tx_nxt = 1'b0;
      ST_DATA:   tx_nxt = shift_nxt[0];
      ST_PARITY: tx_nxt = par_bit;
      ST_STOP:   tx_nxt = 1'b1;
      default:   tx_nxt = 1'b1;
    endcase

    done_nxt = (state == ST_STOP) && (state_nxt == ST_IDLE);
  end

  // Datapath and registered outputs; parity is fixed from the byte at acceptance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift    <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      par_bit  <= 1'b0;
      tx       <= 1'b1;
      tx_done  <= 1'b0;
    end else begin
      shift   <= shift_nxt;
      tx      <= tx_nxt;
      tx_done <= done_nxt;
      if (accept) begin
        bit_idx  <= '0;
        stop_idx <= 1'b0;
        par_bit  <= (^tx_data) ^ (PARITY == PARITY_ODD);
      end else if (tick) begin
        if (state == ST_DATA) bit_idx <= bit_idx + 3'd1;
        if (state == ST_STOP) stop_idx <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at DIV=16 across parity and stop-bit variants.
// Frames are sampled at bit centres and timed from the accept edge to tx_done.
// Four DUT instances share clock, reset and data; each has its own tx_valid.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_data;
  logic [3:0] vld;
  logic [3:0] rdy_v;
  logic [3:0] tx_v;
  logic [3:0] busy_v;
  logic [3:0] done_v;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // u0: no parity, 1 stop; u1: even, 1 stop; u2: odd, 1 stop; u3: no parity, 2 stop
  uart_tx #(.CLK_HZ(16), .BAUD(1), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(vld[0]),
    .tx_ready(rdy_v[0]), .tx(tx_v[0]), .busy(busy_v[0]), .tx_done(done_v[0]));
  uart_tx #(.CLK_HZ(16), .BAUD(1), .PARITY(1), .STOP_BITS(1)) u1 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(vld[1]),
    .tx_ready(rdy_v[1]), .tx(tx_v[1]), .busy(busy_v[1]), .tx_done(done_v[1]));
  uart_tx #(.CLK_HZ(16), .BAUD(1), .PARITY(2), .STOP_BITS(1)) u2 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(vld[2]),
    .tx_ready(rdy_v[2]), .tx(tx_v[2]), .busy(busy_v[2]), .tx_done(done_v[2]));
  uart_tx #(.CLK_HZ(16), .BAUD(1), .PARITY(0), .STOP_BITS(2)) u3 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(vld[3]),
    .tx_ready(rdy_v[3]), .tx(tx_v[3]), .busy(busy_v[3]), .tx_done(done_v[3]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Waits for the accept edge (tx drops), then samples every cycle until tx_done.
  // bits[k] is the line at the centre of bit k; len is accept-to-done in clocks;
  // lowrun is how many clocks the line stayed low from the accept edge onward.
  task automatic capture(input int i, input bit drop, input logic [7:0] nd,
                         output logic [11:0] bits, output int len,
                         output int t0, output int lowrun);
    bit run;
    bits   = '0;
    len    = -1;
    t0     = -1;
    lowrun = 0;
    run    = 1'b1;
    for (int w = 0; w < 400; w++) begin
      @(posedge clk); #1;
      if (tx_v[i] === 1'b0) begin
        t0 = cyc;
        break;
      end
    end
    check("accept_seen", 32'(t0 >= 0), 32'd1);
    if (t0 < 0) return;
    if (drop) vld[i] = 1'b0;
    tx_data = nd;
    for (int off = 0; off < 400; off++) begin
      if (off > 0) begin
        @(posedge clk); #1;
      end
      if (run && tx_v[i] === 1'b0) lowrun++;
      else run = 1'b0;
      if (off % 16 == 8 && off / 16 < 12) bits[off / 16] = tx_v[i];
      if (done_v[i] === 1'b1) begin
        len = off;
        break;
      end
    end
  endtask

  logic [11:0] bits;
  int          len;
  int          t0;
  int          t0b;
  int          lowrun;
  int          cnt;

  initial begin
    rst_n   = 1'b0;
    vld     = '0;
    tx_data = '0;

    // Reset held three clocks: line idle high, ready, no done, not busy
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", 32'(tx_v), 32'hF);
    check("rst_ready", 32'(rdy_v), 32'hF);
    check("rst_done", 32'(done_v), 32'h0);
    check("rst_busy", 32'(busy_v), 32'h0);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("idle_tx", 32'(tx_v), 32'hF);

    // 0xA5, no parity, 1 stop: 0,1,0,1,0,0,1,0,1,1 -> 0x34A, 160 clocks
    tx_data = 8'hA5; vld[0] = 1'b1;
    capture(0, 1'b1, 8'h00, bits, len, t0, lowrun);
    check("a5_p0_bits", 32'(bits), 32'h34A);
    check("a5_p0_len", 32'(len), 32'd160);
    check("a5_p0_ready_at_done", 32'(rdy_v[0]), 32'd1);
    check("a5_p0_busy_at_done", 32'(busy_v[0]), 32'd0);
    check("a5_p0_start_len", 32'(lowrun), 32'd16);
    @(posedge clk); #1;
    check("a5_p0_done_one_cycle", 32'(done_v[0]), 32'd0);

    // 0xA5 even parity: four ones -> parity 0 -> 0x54A, 176 clocks
    tx_data = 8'hA5; vld[1] = 1'b1;
    capture(1, 1'b1, 8'h00, bits, len, t0, lowrun);
    check("a5_even_bits", 32'(bits), 32'h54A);
    check("a5_even_len", 32'(len), 32'd176);

    // 0xA5 odd parity -> parity 1 -> 0x74A
    tx_data = 8'hA5; vld[2] = 1'b1;
    capture(2, 1'b1, 8'h00, bits, len, t0, lowrun);
    check("a5_odd_bits", 32'(bits), 32'h74A);
    check("a5_odd_len", 32'(len), 32'd176);

    // 0x07 even parity: three ones -> parity 1 -> 0x60E
    tx_data = 8'h07; vld[1] = 1'b1;
    capture(1, 1'b1, 8'h00, bits, len, t0, lowrun);
    check("07_even_bits", 32'(bits), 32'h60E);
    check("07_even_len", 32'(len), 32'd176);

    // Two stop bits, tx_valid held: 0x3C then 0xC3 presented while busy
    tx_data = 8'h3C; vld[3] = 1'b1;
    capture(3, 1'b0, 8'hC3, bits, len, t0, lowrun);
    check("s2_f1_bits", 32'(bits), 32'h678);
    check("s2_f1_len", 32'(len), 32'd176);
    capture(3, 1'b1, 8'h00, bits, len, t0b, lowrun);
    check("s2_f2_bits", 32'(bits), 32'h786);
    check("s2_f2_len", 32'(len), 32'd176);
    // start-to-start 176+1; line high from end of bit 7 (144) to next start (177) = 33
    check("s2_start_spacing", 32'(t0b - t0), 32'd177);

    // tx_valid high with 0xFF throughout a 0x5A frame: ignored, no extra frame
    tx_data = 8'h5A; vld[0] = 1'b1;
    capture(0, 1'b0, 8'hFF, bits, len, t0, lowrun);
    vld[0] = 1'b0;
    check("busy_ignore_bits", 32'(bits), 32'h2B4);
    check("busy_ignore_len", 32'(len), 32'd160);
    cnt = 0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      if (tx_v[0] !== 1'b1 || done_v[0] !== 1'b0) cnt++;
    end
    check("no_extra_frame", 32'(cnt), 32'd0);

    // Reset for one clock during data bit 4 of 0x0F (bit 4 is 0)
    tx_data = 8'h0F; vld[0] = 1'b1;
    @(posedge clk); #1;
    vld[0] = 1'b0;
    check("rstmid_start", 32'(tx_v[0]), 32'd0);
    repeat (84) @(posedge clk);
    #1;
    check("rstmid_bit4", 32'(tx_v[0]), 32'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("rstmid_tx", 32'(tx_v[0]), 32'd1);
    check("rstmid_ready", 32'(rdy_v[0]), 32'd1);
    check("rstmid_done", 32'(done_v[0]), 32'd0);
    cnt = 0;
    for (int k = 0; k < 120; k++) begin
      @(posedge clk); #1;
      if (tx_v[0] !== 1'b1 || done_v[0] !== 1'b0) cnt++;
    end
    check("rstmid_quiet", 32'(cnt), 32'd0);

    // 0x55 after the abandoned frame: full 16-clock start bit, correct byte
    tx_data = 8'h55; vld[0] = 1'b1;
    capture(0, 1'b1, 8'h00, bits, len, t0, lowrun);
    check("post_rst_bits", 32'(bits), 32'h2AA);
    check("post_rst_len", 32'(len), 32'd160);
    check("post_rst_start_len", 32'(lowrun), 32'd16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
